// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL lock supervisor: FSM state encoding,
// default parameter values and the counter-width helper.
package pll_rst_pkg;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;
   localparam int unsigned DEF_RST_HOLD_CYC    = 16;
   localparam int unsigned DEF_LOSS_FILTER_CYC = 4;
   localparam int unsigned DEF_CNT_W           = 8;

   typedef enum logic [1:0] {
      StWaitLock,
      StStable,
      StHold,
      StRun
   } state_e;

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pll_lock_rst_ctrl_if.sv
// Lock input, sticky clear and reset/status outputs of the PLL lock supervisor.
interface pll_lock_rst_ctrl_if #(
   parameter int unsigned CNT_W = pll_rst_pkg::DEF_CNT_W
);

   logic             lock;
   logic             clr_sticky;
   logic             sys_rst;
   logic             sys_rdy;
   logic             lock_lost;
   logic [CNT_W-1:0] loss_cnt;

   modport master (
      output lock,
      output clr_sticky,
      input  sys_rst,
      input  sys_rdy,
      input  lock_lost,
      input  loss_cnt
   );

   modport slave (
      input  lock,
      input  clr_sticky,
      output sys_rst,
      output sys_rdy,
      output lock_lost,
      output loss_cnt
   );

endinterface

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with synchronous active-high clear.
module sync_bit #(
   parameter int unsigned SYNC_STAGES = pll_rst_pkg::DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff_q <= '0;
      end else begin
         ff_q <= {ff_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_rst_ctrl.sv
// Holds sys_rst until PLL lock is qualified, then watches for filtered lock loss.
// Define PLL_LOSS_CNT_EN to build the saturating loss-event counter.
module pll_lock_rst_ctrl
   import pll_rst_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
   parameter int unsigned RST_HOLD_CYC    = DEF_RST_HOLD_CYC,
   parameter int unsigned LOSS_FILTER_CYC = DEF_LOSS_FILTER_CYC,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input logic                clk,
   input logic                rst,
   pll_lock_rst_ctrl_if.slave bus
);

   localparam int unsigned STAB_W = cnt_width(LOCK_STABLE_CYC);
   localparam int unsigned HOLD_W = cnt_width(RST_HOLD_CYC);
   localparam int unsigned FILT_W = cnt_width(LOSS_FILTER_CYC);

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER_CYC - 1);

   logic              lock_s;
   state_e            state_q;
   logic [STAB_W-1:0] stab_cnt_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [FILT_W-1:0] filt_cnt_q;
   logic              sys_rst_q;
   logic              sys_rdy_q;
   logic              lock_lost_q;
   logic              loss_evt;

   sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (bus.lock),
      .q  (lock_s)
   );

   // Final low cycle of a filtered loss while running.
   assign loss_evt = (state_q == StRun) && !lock_s && (filt_cnt_q == FILT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StWaitLock;
         stab_cnt_q <= '0;
         hold_cnt_q <= '0;
         filt_cnt_q <= '0;
         sys_rst_q  <= 1'b1;
         sys_rdy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StWaitLock: begin
               if (lock_s) begin
                  state_q    <= StStable;
                  stab_cnt_q <= '0;
               end
            end
            StStable: begin
               if (!lock_s) begin
                  state_q <= StWaitLock;
               end else if (stab_cnt_q == STAB_LAST) begin
                  state_q    <= StHold;
                  hold_cnt_q <= '0;
               end else begin
                  stab_cnt_q <= stab_cnt_q + STAB_W'(1);
               end
            end
            StHold: begin
               if (!lock_s) begin
                  state_q <= StWaitLock;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q    <= StRun;
                  filt_cnt_q <= '0;
                  sys_rst_q  <= 1'b0;
                  sys_rdy_q  <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               end
            end
            StRun: begin
               if (lock_s) begin
                  filt_cnt_q <= '0;
               end else if (loss_evt) begin
                  state_q    <= StWaitLock;
                  filt_cnt_q <= '0;
                  sys_rst_q  <= 1'b1;
                  sys_rdy_q  <= 1'b0;
               end else begin
                  filt_cnt_q <= filt_cnt_q + FILT_W'(1);
               end
            end
            default: begin
               state_q   <= StWaitLock;
               sys_rst_q <= 1'b1;
               sys_rdy_q <= 1'b0;
            end
         endcase
      end
   end

   // A loss event outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_lost_q <= 1'b0;
      end else if (loss_evt) begin
         lock_lost_q <= 1'b1;
      end else if (bus.clr_sticky) begin
         lock_lost_q <= 1'b0;
      end
   end

`ifdef PLL_LOSS_CNT_EN
   logic [CNT_W-1:0] loss_evt_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         loss_evt_cnt_q <= '0;
      end else if (loss_evt) begin
         if (bus.clr_sticky) begin
            loss_evt_cnt_q <= CNT_W'(1);
         end else if (!(&loss_evt_cnt_q)) begin
            loss_evt_cnt_q <= loss_evt_cnt_q + CNT_W'(1);
         end
      end else if (bus.clr_sticky) begin
         loss_evt_cnt_q <= '0;
      end
   end

   assign bus.loss_cnt = loss_evt_cnt_q;
`else
   assign bus.loss_cnt = {CNT_W{1'b0}};
`endif

   assign bus.sys_rst   = sys_rst_q;
   assign bus.sys_rdy   = sys_rdy_q;
   assign bus.lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// Bench for pll_lock_rst_ctrl: directed vector table plus randomized lock traffic
// checked every cycle against a run-length reference model.
module tb_pll_lock_rst_ctrl;

   localparam int unsigned SYNC_STAGES     = 2;
   localparam int unsigned LOCK_STABLE_CYC = 8;
   localparam int unsigned RST_HOLD_CYC    = 4;
   localparam int unsigned LOSS_FILTER_CYC = 3;
   localparam int unsigned CNT_W           = 2;
   localparam int unsigned CNT_MAX         = (1 << CNT_W) - 1;
   localparam int unsigned QUAL_RUN        = LOCK_STABLE_CYC + RST_HOLD_CYC + 1;
`ifdef PLL_LOSS_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      bit          rst;
      bit          lock;
      bit          clr;
      int unsigned cycles;
      bit          e_rst;
      bit          e_rdy;
      bit          e_lost;
      int unsigned e_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   pll_lock_rst_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pll_lock_rst_ctrl #(
      .SYNC_STAGES    (SYNC_STAGES),
      .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
      .RST_HOLD_CYC   (RST_HOLD_CYC),
      .LOSS_FILTER_CYC(LOSS_FILTER_CYC),
      .CNT_W          (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: lock delay line plus run lengths of high/low samples.
   bit          m_sh [SYNC_STAGES];
   int unsigned m_hi   = 0;
   int unsigned m_lo   = 0;
   bit          m_run  = 1'b0;
   bit          m_lost = 1'b0;
   int unsigned m_cnt  = 0;

   vec_t tbl[$];

   function automatic vec_t mk(input bit r, input bit l, input bit c, input int unsigned n,
                               input bit er, input bit ed, input bit el, input int unsigned ec);
      vec_t v;
      v.rst = r; v.lock = l; v.clr = c; v.cycles = n;
      v.e_rst = er; v.e_rdy = ed; v.e_lost = el; v.e_cnt = ec;
      return v;
   endfunction

   function automatic int unsigned ecnt(input int unsigned n);
      return CNT_EN ? n : 0;
   endfunction

   function automatic logic [CNT_W+2:0] dut_outs();
      return {bus.sys_rst, bus.sys_rdy, bus.lock_lost, bus.loss_cnt};
   endfunction

   task automatic check(input string name, input logic [CNT_W+2:0] act,
                        input logic [CNT_W+2:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got rst=%0b rdy=%0b lost=%0b cnt=%0d, want rst=%0b rdy=%0b lost=%0b cnt=%0d",
                  name, $time, act[CNT_W+2], act[CNT_W+1], act[CNT_W], act[CNT_W-1:0],
                  exp[CNT_W+2], exp[CNT_W+1], exp[CNT_W], exp[CNT_W-1:0]);
      end
   endtask

   task automatic model_update(input bit r, input bit l, input bit c);
      bit ls;
      bit loss;
      if (r) begin
         for (int i = 0; i < SYNC_STAGES; i++) m_sh[i] = 1'b0;
         m_hi = 0; m_lo = 0; m_run = 1'b0; m_lost = 1'b0; m_cnt = 0;
         return;
      end
      ls = m_sh[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
      m_sh[0] = l;
      loss = 1'b0;
      if (m_run) begin
         m_lo = ls ? 0 : m_lo + 1;
         if (m_lo == LOSS_FILTER_CYC) begin
            m_run = 1'b0; m_lo = 0; loss = 1'b1;
         end
      end else begin
         m_hi = ls ? m_hi + 1 : 0;
         if (m_hi == QUAL_RUN) begin
            m_run = 1'b1; m_hi = 0;
         end
      end
      if (loss) begin
         m_lost = 1'b1;
         m_cnt  = c ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
      end else if (c) begin
         m_lost = 1'b0;
         m_cnt  = 0;
      end
   endtask

   task automatic step(input bit r, input bit l, input bit c);
      logic [CNT_W-1:0] ec;
      rst = r; bus.lock = l; bus.clr_sticky = c;
      @(posedge clk);
      model_update(r, l, c);
      #1;
      ec = CNT_EN ? CNT_W'(m_cnt) : '0;
      check("model", dut_outs(), {!m_run, m_run, m_lost, ec});
   endtask

   initial begin
      logic [CNT_W-1:0] ec;
      bit               lv;
      bit               rr;
      bit               cc;
      int unsigned      len;

      for (int i = 0; i < SYNC_STAGES; i++) m_sh[i] = 1'b0;
      rst = 1'b1; bus.lock = 1'b0; bus.clr_sticky = 1'b0;

      // Reset state, then steady lock held through reset deassertion.
      tbl.push_back(mk(1, 0, 0,  2, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0,  1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 14, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0));
      // Two-cycle low pulse filtered out; three-cycle low is a loss at edge 5.
      tbl.push_back(mk(0, 0, 0,  2, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  3, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  4, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 1, 0, 1, ecnt(1)));
      tbl.push_back(mk(0, 0, 1,  1, 1, 0, 0, 0));
      // One-cycle glitch while qualifying restarts the count without LOCK_LOST.
      tbl.push_back(mk(0, 1, 0,  5, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 14, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0));
      // Four loss events with re-lock; counter saturates at CNT_MAX.
      for (int k = 1; k <= 4; k++) begin
         tbl.push_back(mk(0, 0, 0,  4, 0, 1, k > 1, ecnt((k - 1 > 3) ? 3 : k - 1)));
         tbl.push_back(mk(0, 0, 0,  1, 1, 0, 1, ecnt((k > 3) ? 3 : k)));
         tbl.push_back(mk(0, 1, 0, 14, 1, 0, 1, ecnt((k > 3) ? 3 : k)));
         tbl.push_back(mk(0, 1, 0,  1, 0, 1, 1, ecnt((k > 3) ? 3 : k)));
      end
      tbl.push_back(mk(0, 1, 1,  1, 0, 1, 0, 0));
      // Clear coinciding with the loss edge: the loss wins.
      tbl.push_back(mk(0, 0, 0,  4, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1,  1, 1, 0, 1, ecnt(1)));
      // Reset while in the hold phase, then a full release.
      tbl.push_back(mk(0, 1, 0, 12, 1, 0, 1, ecnt(1)));
      tbl.push_back(mk(1, 1, 0,  1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 14, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0));

      foreach (tbl[i]) begin
         for (int k = 0; k < int'(tbl[i].cycles); k++) step(tbl[i].rst, tbl[i].lock, tbl[i].clr);
         ec = CNT_W'(tbl[i].e_cnt);
         check($sformatf("table[%0d]", i), dut_outs(),
               {tbl[i].e_rst, tbl[i].e_rdy, tbl[i].e_lost, ec});
      end

      // Random lock traffic: mostly long highs, short lows around the filter length.
      for (int seg = 0; seg < 160; seg++) begin
         lv  = ($urandom_range(0, 9) < 7);
         len = lv ? $urandom_range(1, 40) : $urandom_range(1, 6);
         for (int k = 0; k < int'(len); k++) begin
            rr = ($urandom_range(0, 299) == 0);
            cc = ($urandom_range(0, 24) == 0);
            step(rr, lv, cc);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
